// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and write-back stage: MemtoReg mux, register-file
// write port, WB-to-EX forwarding-match flags and a retired-instruction counter.
module mem_wb_writeback #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              mem_valid,
   input  logic [DATA_W-1:0] mem_read_data,
   input  logic [DATA_W-1:0] mem_alu_result,
   input  logic [REG_W-1:0]  mem_dest_reg,
   input  logic              mem_reg_write,
   input  logic              mem_memto_reg,
   input  logic [REG_W-1:0]  ex_rs,
   input  logic [REG_W-1:0]  ex_rt,
   output logic [DATA_W-1:0] wb_write_data,
   output logic [REG_W-1:0]  wb_dest_reg,
   output logic              wb_reg_write,
   output logic              wb_valid,
   output logic              fwd_rs_hit,
   output logic              fwd_rt_hit,
   output logic [CNT_W-1:0]  retired_count
);

   logic              valid_q;
   logic              reg_write_q;
   logic              memto_reg_q;
   logic [DATA_W-1:0] read_data_q;
   logic [DATA_W-1:0] alu_result_q;
   logic [REG_W-1:0]  dest_q;
   logic [CNT_W-1:0]  count_q;
   logic              write_en;

   // Pipeline register: flush bubbles the control bits only, data fields hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q      <= 1'b0;
         reg_write_q  <= 1'b0;
         memto_reg_q  <= 1'b0;
         read_data_q  <= '0;
         alu_result_q <= '0;
         dest_q       <= '0;
      end else if (flush) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
      end else if (!stall) begin
         valid_q      <= mem_valid;
         reg_write_q  <= mem_reg_write;
         memto_reg_q  <= mem_memto_reg;
         read_data_q  <= mem_read_data;
         alu_result_q <= mem_alu_result;
         dest_q       <= mem_dest_reg;
      end
   end

   // An instruction retires on the edge where it leaves WB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (valid_q && !stall && !flush) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign write_en      = valid_q & reg_write_q & (dest_q != '0);
   assign wb_write_data = memto_reg_q ? read_data_q : alu_result_q;
   assign wb_dest_reg   = dest_q;
   assign wb_reg_write  = write_en;
   assign wb_valid      = valid_q;
   assign fwd_rs_hit    = write_en & (dest_q == ex_rs);
   assign fwd_rt_hit    = write_en & (dest_q == ex_rt);
   assign retired_count = count_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Self-checking bench for mem_wb_writeback: directed cases plus randomized
// stimulus against an instruction-level reference model (32- and 4-bit counters).
module tb_mem_wb_writeback;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, flush, mem_valid, mem_reg_write, mem_memto_reg;
   logic [31:0] mem_read_data, mem_alu_result;
   logic [4:0]  mem_dest_reg, ex_rs, ex_rt;

   logic [31:0] wb_write_data, wb_write_data4;
   logic [4:0]  wb_dest_reg, wb_dest_reg4;
   logic        wb_reg_write, wb_valid, fwd_rs_hit, fwd_rt_hit;
   logic        wb_reg_write4, wb_valid4, fwd_rs_hit4, fwd_rt_hit4;
   logic [31:0] retired_count;
   logic [3:0]  retired_count4;

   int total = 0;
   int bad   = 0;

   // Reference model: the instruction sitting in WB and the commit tally.
   typedef struct {
      bit          valid;
      bit [31:0]   rd;
      bit [31:0]   alu;
      bit [4:0]    dest;
      bit          rw;
      bit          m2r;
   } instr_t;
   instr_t      m_wb;
   int unsigned m_commits;

   always #5 clk = ~clk;

   mem_wb_writeback #(.DATA_W(32), .REG_W(5), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .mem_valid(mem_valid), .mem_read_data(mem_read_data),
      .mem_alu_result(mem_alu_result), .mem_dest_reg(mem_dest_reg),
      .mem_reg_write(mem_reg_write), .mem_memto_reg(mem_memto_reg),
      .ex_rs(ex_rs), .ex_rt(ex_rt),
      .wb_write_data(wb_write_data), .wb_dest_reg(wb_dest_reg),
      .wb_reg_write(wb_reg_write), .wb_valid(wb_valid),
      .fwd_rs_hit(fwd_rs_hit), .fwd_rt_hit(fwd_rt_hit),
      .retired_count(retired_count)
   );

   mem_wb_writeback #(.DATA_W(32), .REG_W(5), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .mem_valid(mem_valid), .mem_read_data(mem_read_data),
      .mem_alu_result(mem_alu_result), .mem_dest_reg(mem_dest_reg),
      .mem_reg_write(mem_reg_write), .mem_memto_reg(mem_memto_reg),
      .ex_rs(ex_rs), .ex_rt(ex_rt),
      .wb_write_data(wb_write_data4), .wb_dest_reg(wb_dest_reg4),
      .wb_reg_write(wb_reg_write4), .wb_valid(wb_valid4),
      .fwd_rs_hit(fwd_rs_hit4), .fwd_rt_hit(fwd_rt_hit4),
      .retired_count(retired_count4)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit exp_we();
      return m_wb.valid && m_wb.rw && (m_wb.dest != 5'd0);
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".wd"},   wb_write_data, m_wb.m2r ? m_wb.rd : m_wb.alu);
      chk({tag, ".dst"},  wb_dest_reg, m_wb.dest);
      chk({tag, ".we"},   wb_reg_write, exp_we());
      chk({tag, ".v"},    wb_valid, m_wb.valid);
      chk({tag, ".frs"},  fwd_rs_hit, exp_we() && (m_wb.dest == ex_rs));
      chk({tag, ".frt"},  fwd_rt_hit, exp_we() && (m_wb.dest == ex_rt));
      chk({tag, ".cnt"},  retired_count, 64'(m_commits));
      chk({tag, ".cnt4"}, retired_count4, 64'(m_commits % 16));
   endtask

   task automatic model_reset();
      m_wb      = '{default: 0};
      m_commits = 0;
   endtask

   // One clock: advance the model with the inputs present at the edge, then check.
   task automatic step(input string tag);
      @(posedge clk);
      if (m_wb.valid && !stall && !flush) m_commits++;
      if (flush) begin
         m_wb.valid = 1'b0;
         m_wb.rw    = 1'b0;
      end else if (!stall) begin
         m_wb.valid = mem_valid;
         m_wb.rd    = mem_read_data;
         m_wb.alu   = mem_alu_result;
         m_wb.dest  = mem_dest_reg;
         m_wb.rw    = mem_reg_write;
         m_wb.m2r   = mem_memto_reg;
      end
      #1;
      check_all(tag);
   endtask

   task automatic drive(input bit v, input bit [31:0] rd, input bit [31:0] alu,
                        input bit [4:0] dst, input bit rw, input bit m2r);
      mem_valid      = v;
      mem_read_data  = rd;
      mem_alu_result = alu;
      mem_dest_reg   = dst;
      mem_reg_write  = rw;
      mem_memto_reg  = m2r;
   endtask

   // Asynchronous reset pulse between edges; outputs must clear without a clock.
   task automatic async_reset(input string tag);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk({tag, ".wd"},   wb_write_data, 0);
      chk({tag, ".dst"},  wb_dest_reg, 0);
      chk({tag, ".we"},   wb_reg_write, 0);
      chk({tag, ".v"},    wb_valid, 0);
      chk({tag, ".frs"},  fwd_rs_hit, 0);
      chk({tag, ".frt"},  fwd_rt_hit, 0);
      chk({tag, ".cnt"},  retired_count, 0);
      chk({tag, ".cnt4"}, retired_count4, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bit [31:0] frz_wd;
      bit [4:0]  frz_dst;
      bit [31:0] frz_cnt;

      rst_n = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      ex_rs = 5'd0;
      ex_rt = 5'd0;
      drive(0, 0, 0, 0, 0, 0);
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Load path
      drive(1, 32'hDEADBEEF, 32'h10, 5'd8, 1, 1);
      step("load");
      chk("load_wd", wb_write_data, 32'hDEADBEEF);
      chk("load_dst", wb_dest_reg, 8);
      chk("load_we", wb_reg_write, 1);

      // R-type to $0: write suppressed, no forwarding even with ex_rs=0
      drive(1, 32'hAAAA5555, 32'h12345678, 5'd0, 1, 0);
      ex_rs = 5'd0;
      step("rtype0");
      chk("load_retired", retired_count, 1);
      chk("r0_wd", wb_write_data, 32'h12345678);
      chk("r0_we", wb_reg_write, 0);
      chk("r0_frs", fwd_rs_hit, 0);

      // Forwarding, including same-cycle response to ex_rt
      drive(1, $urandom, $urandom, 5'd9, 1, 0);
      ex_rs = 5'd9;
      ex_rt = 5'd10;
      step("fwd");
      chk("fwd_rs", fwd_rs_hit, 1);
      chk("fwd_rt0", fwd_rt_hit, 0);
      ex_rt = 5'd9;
      #1;
      chk("fwd_rt1", fwd_rt_hit, 1);
      check_all("fwd_comb");

      // Stall three cycles with changing inputs: outputs and counter frozen
      frz_wd  = wb_write_data;
      frz_dst = wb_dest_reg;
      frz_cnt = retired_count;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1, $urandom, $urandom, 5'($urandom), 1, 1'($urandom));
         step("stall");
         chk("stall_wd", wb_write_data, frz_wd);
         chk("stall_dst", wb_dest_reg, frz_dst);
         chk("stall_cnt", retired_count, frz_cnt);
      end
      flush = 1'b1;
      step("stflush");
      chk("stflush_v", wb_valid, 0);
      chk("stflush_we", wb_reg_write, 0);
      stall = 1'b0;
      flush = 1'b0;

      // Async reset while valid with five retirements
      async_reset("rst_a");
      drive(1, $urandom, $urandom, 5'd3, 1, 0);
      for (int i = 0; i < 6; i++) step("fill");
      chk("pre_rst_cnt", retired_count, 5);
      chk("pre_rst_v", wb_valid, 1);
      async_reset("rst_b");

      // 17 commits wrap the 4-bit counter to 1
      drive(1, $urandom, $urandom, 5'd4, 1, 1);
      for (int i = 0; i < 18; i++) step("wrapfill");
      chk("wrap_cnt4", retired_count4, 1);
      chk("wrap_cnt", retired_count, 17);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 149) == 0) async_reset("rnd_rst");
         stall = ($urandom_range(0, 4) == 0);
         flush = ($urandom_range(0, 7) == 0);
         ex_rs = 5'($urandom_range(0, 3));
         ex_rt = 5'($urandom_range(0, 3));
         drive(($urandom_range(0, 3) != 0), $urandom, $urandom,
               5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
         step("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
